// File: rtl/game_tick_gen.sv
// -----------------------------------------------------------------------------
// game_tick_gen
// Multi-channel game-tick generator. Each channel counts 0..P_k and emits a
// one-cycle registered o_mv[k] pulse on every wrap, so its tick period is
// P_k+1 cycles. Channel 0 wraps also feed a STEP_DIV prescaler that advances a
// saturating game-time step counter.
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous active-high reset (also clears shadow periods)
//   i_run        game active; low forces IDLE and clears counters/outputs
//   i_pause      freezes all counters while high
//   i_reload     strobe: relatch i_period and restart all channel counters
//   i_period     per-channel period P_k in [k*CNT_WIDTH +: CNT_WIDTH]
//   o_mv         per-channel one-cycle tick
//   o_time_step  elapsed game-time steps, saturating at all-ones
//   o_step_tick  one-cycle pulse on each o_time_step increment
//   o_sat        sticky, o_time_step has reached all-ones
//   o_active     high while in RUN
// -----------------------------------------------------------------------------
module game_tick_gen #(
    parameter int NUM_CH     = 2,
    parameter int CNT_WIDTH  = 23,
    parameter int STEP_DIV   = 1000,
    parameter int STEP_WIDTH = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_run,
    input  logic                        i_pause,
    input  logic                        i_reload,
    input  logic [NUM_CH*CNT_WIDTH-1:0] i_period,
    output logic [NUM_CH-1:0]           o_mv,
    output logic [STEP_WIDTH-1:0]       o_time_step,
    output logic                        o_step_tick,
    output logic                        o_sat,
    output logic                        o_active
);

    localparam int SC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_cnt [NUM_CH];
    logic [CNT_WIDTH-1:0]  r_per [NUM_CH];
    logic [SC_W-1:0]       r_step_cnt;
    logic [STEP_WIDTH-1:0] r_time_step;
    logic                  r_sat;
    logic [NUM_CH-1:0]     r_mv;
    logic                  r_step_tick;
    logic                  r_active;

    logic [NUM_CH-1:0]     w_wrap;
    logic                  w_adv;
    logic [STEP_WIDTH-1:0] w_ts_inc;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            w_wrap[k] = (r_cnt[k] == r_per[k]);
        end
    end

    // Counting edges: plain RUN, and also the edge that leaves PAUSE. Letting
    // the exit edge count keeps the delay exactly equal to the number of
    // cycles i_pause was sampled high (the entry edge is the frozen one).
    assign w_adv = i_run &&
                   (((r_state == S_RUN) && !i_pause && !i_reload) ||
                    ((r_state == S_PAUSE) && !i_pause));

    assign w_ts_inc = r_time_step + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_step_cnt  <= '0;
            r_time_step <= '0;
            r_sat       <= 1'b0;
            r_mv        <= '0;
            r_step_tick <= 1'b0;
            r_active    <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_cnt[k] <= '0;
                r_per[k] <= '0;
            end
        end else if (!i_run) begin
            // Same clear as reset, but the shadow periods survive.
            r_state     <= S_IDLE;
            r_step_cnt  <= '0;
            r_time_step <= '0;
            r_sat       <= 1'b0;
            r_mv        <= '0;
            r_step_tick <= 1'b0;
            r_active    <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_mv        <= '0;
            r_step_tick <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_state  <= S_RUN;
                    r_active <= 1'b1;
                    for (int k = 0; k < NUM_CH; k++) begin
                        r_per[k] <= i_period[k*CNT_WIDTH +: CNT_WIDTH];
                        r_cnt[k] <= '0;
                    end
                end
                S_RUN: begin
                    if (i_pause) begin
                        r_state  <= S_PAUSE;
                        r_active <= 1'b0;
                    end else if (i_reload) begin
                        // Reload beats a coincident wrap: no tick, step_cnt untouched.
                        for (int k = 0; k < NUM_CH; k++) begin
                            r_per[k] <= i_period[k*CNT_WIDTH +: CNT_WIDTH];
                            r_cnt[k] <= '0;
                        end
                    end
                end
                S_PAUSE: begin
                    if (!i_pause) begin
                        r_state  <= S_RUN;
                        r_active <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_active <= 1'b0;
                end
            endcase

            if (w_adv) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (w_wrap[k]) begin
                        r_cnt[k] <= '0;
                        r_mv[k]  <= 1'b1;
                    end else begin
                        r_cnt[k] <= r_cnt[k] + 1'b1;
                    end
                end

                if (w_wrap[0]) begin
                    if (r_step_cnt == SC_W'(STEP_DIV - 1)) begin
                        r_step_cnt <= '0;
                        // Once saturated the prescaler keeps wrapping silently.
                        if (!(&r_time_step)) begin
                            r_time_step <= w_ts_inc;
                            r_step_tick <= 1'b1;
                            if (&w_ts_inc) r_sat <= 1'b1;
                        end
                    end else begin
                        r_step_cnt <= r_step_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign o_mv        = r_mv;
    assign o_time_step = r_time_step;
    assign o_step_tick = r_step_tick;
    assign o_sat       = r_sat;
    assign o_active    = r_active;

endmodule

// File: tb/tb_game_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_game_tick_gen
// Stimulus process drives inputs and pushes the expected outputs (from a
// behavioural model based on elapsed counting cycles and total channel-0
// wraps) into a queue; a negedge monitor pops and compares every cycle.
// -----------------------------------------------------------------------------
module tb_game_tick_gen;

    localparam int NUM_CH     = 2;
    localparam int CNT_WIDTH  = 8;
    localparam int STEP_DIV   = 4;
    localparam int STEP_WIDTH = 2;
    localparam int TS_MAX     = (1 << STEP_WIDTH) - 1;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        run = 1'b0;
    logic                        pause = 1'b0;
    logic                        reload = 1'b0;
    logic [NUM_CH*CNT_WIDTH-1:0] period = '0;
    logic [NUM_CH-1:0]           mv;
    logic [STEP_WIDTH-1:0]       time_step;
    logic                        step_tick;
    logic                        sat;
    logic                        active;

    game_tick_gen #(
        .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH),
        .STEP_DIV(STEP_DIV), .STEP_WIDTH(STEP_WIDTH)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_pause(pause),
        .i_reload(reload), .i_period(period),
        .o_mv(mv), .o_time_step(time_step), .o_step_tick(step_tick),
        .o_sat(sat), .o_active(active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_CH-1:0]     mv;
        logic [STEP_WIDTH-1:0] ts;
        logic                  tick;
        logic                  sat;
        logic                  act;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    // Reference model: 0 idle, 1 run, 2 pause
    int      m_state = 0;
    longint  m_el = 0;        // counting edges since entry/reload
    int      m_w = 0;         // channel-0 wraps since entry
    longint  m_p [NUM_CH];

    task automatic model_edge();
        exp_t e;
        bit   adv;
        adv = 1'b0;
        if (rst) begin
            m_state = 0; m_el = 0; m_w = 0;
            for (int k = 0; k < NUM_CH; k++) m_p[k] = 0;
        end else if (!run) begin
            m_state = 0; m_el = 0; m_w = 0;
        end else begin
            case (m_state)
                0: begin
                    for (int k = 0; k < NUM_CH; k++) m_p[k] = period[k*CNT_WIDTH +: CNT_WIDTH];
                    m_el = 0; m_w = 0; m_state = 1;
                end
                1: begin
                    if (pause) m_state = 2;
                    else if (reload) begin
                        for (int k = 0; k < NUM_CH; k++) m_p[k] = period[k*CNT_WIDTH +: CNT_WIDTH];
                        m_el = 0;
                    end else adv = 1'b1;
                end
                default: begin
                    if (!pause) begin m_state = 1; adv = 1'b1; end
                end
            endcase
        end
        e.mv = '0;
        e.tick = 1'b0;
        if (adv) begin
            m_el++;
            for (int k = 0; k < NUM_CH; k++) e.mv[k] = ((m_el % (m_p[k] + 1)) == 0);
            if (e.mv[0]) begin
                m_w++;
                e.tick = ((m_w % STEP_DIV) == 0) && ((m_w / STEP_DIV) <= TS_MAX);
            end
        end
        e.ts  = STEP_WIDTH'(((m_w / STEP_DIV) > TS_MAX) ? TS_MAX : (m_w / STEP_DIV));
        e.sat = ((m_w / STEP_DIV) >= TS_MAX);
        e.act = (m_state == 1);
        q.push_back(e);
    endtask

    task automatic step(input bit r, input bit ru, input bit pa, input bit rl);
        rst = r; run = ru; pause = pa; reload = rl;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_per(input int p0, input int p1);
        period = {CNT_WIDTH'(p1), CNT_WIDTH'(p0)};
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        exp_t g;
        cyc++;
        if (q.size() != 0) begin
            e = q.pop_front();
            g = {mv, time_step, step_tick, sat, active};
            n_chk++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d: got mv=%b ts=%0d tick=%b sat=%b act=%b, want mv=%b ts=%0d tick=%b sat=%b act=%b",
                         cyc, g.mv, g.ts, g.tick, g.sat, g.act, e.mv, e.ts, e.tick, e.sat, e.act);
            end
        end
    end

    initial begin
        // Reset
        set_per(3, 5);
        repeat (2) step(1, 0, 0, 0);
        // Basic period P={3,5}
        repeat (20) step(0, 1, 0, 0);
        // Pause 7 cycles right after first mv[0]
        step(0, 0, 0, 0);
        set_per(3, 5);
        repeat (5) step(0, 1, 0, 0);
        repeat (7) step(0, 1, 1, 0);
        repeat (12) step(0, 1, 0, 0);
        // Reload mid-count to P0=1, then reloads at several phases
        repeat (2) step(0, 1, 0, 0);
        set_per(1, 2);
        step(0, 1, 0, 1);
        repeat (8) step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            repeat (i) step(0, 1, 0, 0);
            step(0, 1, 0, 1);
        end
        step(0, 1, 1, 1);          // pause beats reload
        step(0, 1, 1, 1);          // reload ignored in pause
        repeat (4) step(0, 1, 0, 0);
        // Time step and saturation with P0=0
        step(0, 0, 0, 0);
        set_per(0, 2);
        repeat (10) step(0, 1, 0, 0);
        repeat (3) step(0, 1, 1, 0);
        repeat (12) step(0, 1, 0, 0);
        // Clear paths: drop run mid-count, re-raise, reset in pause
        set_per(4, 3);
        step(0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        repeat (12) step(0, 1, 0, 0);
        repeat (2) step(0, 1, 1, 0);
        step(1, 1, 1, 0);
        step(0, 0, 0, 0);
        // Degenerate period then pause
        set_per(0, 0);
        repeat (5) step(0, 1, 0, 0);
        repeat (3) step(0, 1, 1, 0);
        repeat (3) step(0, 1, 0, 0);
        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int k = 0; k < NUM_CH; k++)
                    period[k*CNT_WIDTH +: CNT_WIDTH] =
                        CNT_WIDTH'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 30) : $urandom_range(0, 6));
            end
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 14) == 0));
        end
        step(0, 0, 0, 0);
        @(negedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
